// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory between instruction fetch and
// the load/store port; sequences the start/ready handshake and returns read data.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_rwn,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_start,
    output logic          mem_rwn,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    input  logic          mem_ready,
    output logic          busy,
    output logic          timeout_err
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {FETCH, DATA} grant_t;

    state_t        state_q;
    grant_t        gnt_q, last_q;
    grant_t        gnt_d;
    logic          gnt_vld_d;
    logic          seen_low_q;
    logic [TW-1:0] timer_q;
    logic          mem_start_q, mem_rwn_q, if_ack_q, d_ack_q, busy_q, timeout_err_q;
    logic [AW-1:0] mem_address_q;
    logic [DW-1:0] mem_data_in_q, if_rdata_q, d_rdata_q;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt_vld_d = mem_ready && (if_req || d_req);
        gnt_d     = FETCH;
        if (d_req && (!if_req || last_q == FETCH)) begin
            gnt_d = DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= FETCH;
            last_q        <= FETCH;
            seen_low_q    <= 1'b0;
            timer_q       <= '0;
            mem_start_q   <= 1'b0;
            mem_rwn_q     <= 1'b1;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        mem_start_q <= 1'b1;
                        gnt_q       <= gnt_d;
                        last_q      <= gnt_d;
                        if (gnt_d == DATA) begin
                            mem_address_q <= d_addr;
                            mem_rwn_q     <= d_rwn;
                            mem_data_in_q <= d_wdata;
                        end else begin
                            mem_address_q <= if_addr;
                            mem_rwn_q     <= 1'b1;
                            mem_data_in_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_start_q <= 1'b0;
                    seen_low_q  <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (!mem_ready) begin
                        seen_low_q <= 1'b1;
                    end
                    // Completion needs a busy phase first so a stale ready is never taken as done.
                    if (seen_low_q && mem_ready) begin
                        if (mem_rwn_q) begin
                            if (gnt_q == DATA) d_rdata_q  <= mem_data_out;
                            else               if_rdata_q <= mem_data_out;
                        end
                        state_q  <= ACK;
                        if_ack_q <= (gnt_q == FETCH);
                        d_ack_q  <= (gnt_q == DATA);
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ACK;
                        if_ack_q      <= (gnt_q == FETCH);
                        d_ack_q       <= (gnt_q == DATA);
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ACK: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_start   = mem_start_q;
    assign mem_rwn     = mem_rwn_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, arbitration/timeout/reset sequences and
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'h00;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_rwn = 1'b1;
    logic [7:0]  d_addr = 8'h00;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_start, mem_rwn;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out = 16'h0000;
    logic        mem_ready = 1'b1;
    logic        busy, timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_rwn(d_rwn), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Memory stub: ready drops the cycle after start and stays low for addr[1:0]+1 cycles.
    logic [15:0] smem [256];
    logic [1:0]  s_cnt = 2'd0;
    logic        s_stuck = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [15:0] pl_data = 16'h0000;

    always @(posedge clk) begin
        if (pl_en) smem[pl_addr] <= pl_data;
        if (mem_start) begin
            mem_ready    <= 1'b0;
            s_cnt        <= mem_address[1:0];
            mem_data_out <= smem[mem_address];
            if (!mem_rwn) smem[mem_address] <= mem_data_in;
        end else if (!mem_ready && !s_stuck) begin
            if (s_cnt == 2'd0) mem_ready <= 1'b1;
            else               s_cnt <= s_cnt - 2'd1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_if, exp_d;
    bit          last_d;

    typedef struct {
        bit          is_d;
        bit          rwn;
        logic [7:0]  addr;
        logic [15:0] wd;
        int          lat;
        logic [15:0] e_if;
        logic [15:0] e_d;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic pl(input logic [7:0] a, input logic [15:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = v; ref_mem[a] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_txn(input string nm, input bit is_d, input bit rwn, input logic [7:0] a,
                          input logic [15:0] wd, input int lat_req,
                          input logic [15:0] e_if, input logic [15:0] e_d);
        int  lat;
        int  starts;
        bit  got;
        lat = 0; starts = 0; got = 1'b0;
        @(negedge clk);
        if (is_d) begin d_req = 1'b1; d_rwn = rwn; d_addr = a; d_wdata = wd; end
        else      begin if_req = 1'b1; if_addr = a; end
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (mem_start) begin
                starts++;
                check({nm, "_addr"}, 32'(mem_address), 32'(a));
                check({nm, "_rwn"}, 32'(mem_rwn), 32'(is_d ? rwn : 1'b1));
                if (!is_d || !rwn) check({nm, "_wdata"}, 32'(mem_data_in), 32'(is_d ? wd : 16'h0));
            end
            if (if_ack || d_ack) begin
                got = 1'b1; lat = c;
                check({nm, "_ackid"}, {30'd0, if_ack, d_ack}, is_d ? 32'd1 : 32'd2);
                check({nm, "_if_rdata"}, 32'(if_rdata), 32'(e_if));
                check({nm, "_d_rdata"}, 32'(d_rdata), 32'(e_d));
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check({nm, "_acked"}, 32'(got), 32'd1);
        check({nm, "_latency"}, 32'(lat), 32'(lat_req));
        check({nm, "_starts"}, 32'(starts), 32'd1);
        @(negedge clk);
        check({nm, "_idle"}, {29'd0, busy, if_ack, d_ack}, 32'd0);
    endtask

    task automatic tie_test();
        int fl, dl, n, ovl;
        int ord [4];
        fl = 2; dl = 2; n = 0; ovl = 0;
        for (int k = 0; k < 4; k++) ord[k] = 7;
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h00; d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'h01;
        for (int c = 0; c < 100 && (fl > 0 || dl > 0); c++) begin
            @(negedge clk);
            if (if_ack && d_ack) ovl++;
            if (d_ack) begin
                if (n < 4) ord[n] = 1;
                n++; dl--;
                check("tie_d_rdata", 32'(d_rdata), 32'(ref_mem[1]));
                if (dl <= 0) d_req = 1'b0;
            end
            if (if_ack) begin
                if (n < 4) ord[n] = 0;
                n++; fl--;
                check("tie_if_rdata", 32'(if_rdata), 32'(ref_mem[0]));
                if (fl <= 0) if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie_count", 32'(n), 32'd4);
        check("tie_overlap", 32'(ovl), 32'd0);
        for (int k = 0; k < 4; k++) check($sformatf("tie_order%0d", k), 32'(ord[k]), 32'(1 - (k % 2)));
        @(negedge clk);
    endtask

    task automatic rand_iter(input int it);
        int          pat, t, ef, ed;
        bit          wf, wdq, rw, first_d, take_d, got_f, got_d;
        logic [7:0]  fa, da;
        logic [15:0] wdat;
        pat = int'($urandom_range(1, 3));
        wf = (pat != 2); wdq = (pat != 1);
        fa = 8'($urandom); da = 8'($urandom); rw = 1'($urandom); wdat = 16'($urandom);
        first_d = wdq && (!wf || !last_d);
        t = 0; ef = -1; ed = -1;
        for (int k = 0; k < 2; k++) begin
            take_d = (k == 0) ? first_d : !first_d;
            if (take_d && wdq) begin
                t += 4 + int'(da[1:0]); ed = t; t += 1;
                if (rw) exp_d = ref_mem[da];
                else    ref_mem[da] = wdat;
                last_d = 1'b1;
            end else if (!take_d && wf) begin
                t += 4 + int'(fa[1:0]); ef = t; t += 1;
                exp_if = ref_mem[fa];
                last_d = 1'b0;
            end
        end
        @(negedge clk);
        if_req = wf; if_addr = fa; d_req = wdq; d_rwn = rw; d_addr = da; d_wdata = wdat;
        got_f = !wf; got_d = !wdq;
        for (int c = 1; c <= 60 && !(got_f && got_d); c++) begin
            @(negedge clk);
            if (if_ack || d_ack) check($sformatf("rnd%0d_overlap", it), 32'(if_ack & d_ack), 32'd0);
            if (if_ack) begin
                check($sformatf("rnd%0d_if_lat", it), 32'(c), 32'(ef));
                check($sformatf("rnd%0d_if_rdata", it), 32'(if_rdata), 32'(exp_if));
                got_f = 1'b1; if_req = 1'b0;
            end
            if (d_ack) begin
                check($sformatf("rnd%0d_d_lat", it), 32'(c), 32'(ed));
                check($sformatf("rnd%0d_d_rdata", it), 32'(d_rdata), 32'(exp_d));
                got_d = 1'b1; d_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check($sformatf("rnd%0d_done", it), 32'(got_f && got_d), 32'd1);
    endtask

    task automatic reset_mid_test();
        int acks;
        acks = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h03;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_mid_start", 32'(mem_start), 32'd0);
        check("rst_mid_rwn", 32'(mem_rwn), 32'd1);
        check("rst_mid_addr", 32'(mem_address), 32'd0);
        check("rst_mid_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_mid_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if_ack || d_ack) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'd0);
        exp_if = ref_mem[0]; exp_d = 16'h0000;
        do_txn("rst_mid_fetch", 1'b0, 1'b1, 8'h00, 16'h0, 4, exp_if, exp_d);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h00, 16'h0000, 4, 16'h6884, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 8'hF5, 16'h0000, 5, 16'h6884, 16'h0008};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 16'h1234, 4, 16'h6884, 16'h0008};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 16'h0000, 4, 16'h1234, 16'h0008};
        tbl[4] = '{1'b1, 1'b1, 8'h03, 16'h0000, 7, 16'h1234, 16'hBEEF};
        tbl[5] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 7, 16'hA5A5, 16'hBEEF};
        tbl[6] = '{1'b1, 1'b0, 8'hFF, 16'h0F0F, 7, 16'hA5A5, 16'hBEEF};
        tbl[7] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 7, 16'h0F0F, 16'hBEEF};
        tbl[8] = '{1'b1, 1'b1, 8'h00, 16'h0000, 4, 16'h0F0F, 16'h1234};

        for (int i = 0; i < 256; i++) pl(8'(i), 16'(i * 257) ^ 16'h5A3C);
        pl(8'h00, 16'h6884);
        pl(8'hF5, 16'h0008);
        pl(8'h03, 16'hBEEF);
        pl(8'hFF, 16'hA5A5);
        @(negedge clk);
        pl_en = 1'b0;

        check("rst_mem_start", 32'(mem_start), 32'd0);
        check("rst_mem_rwn", 32'(mem_rwn), 32'd1);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].is_d, tbl[i].rwn, tbl[i].addr, tbl[i].wd,
                   tbl[i].lat, tbl[i].e_if, tbl[i].e_d);
            if (tbl[i].is_d && !tbl[i].rwn) ref_mem[tbl[i].addr] = tbl[i].wd;
        end

        do_reset();
        tie_test();

        do_reset();
        exp_if = 16'h0000; exp_d = 16'h0000; last_d = 1'b0;
        for (int it = 0; it < 40; it++) rand_iter(it);

        s_stuck = 1'b1;
        do_txn("timeout", 1'b0, 1'b1, 8'h04, 16'h0, 17, exp_if, exp_d);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        s_stuck = 1'b0;
        repeat (4) @(negedge clk);
        exp_if = ref_mem[0];
        do_txn("after_timeout", 1'b0, 1'b1, 8'h00, 16'h0, 4, exp_if, exp_d);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        reset_mid_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single multi-cycle 256x16 memory between two requesters: the instruction-fetch unit (read-only) and the load/store data port (read/write).
- Arbitrates with a round-robin policy and sequences the memory start/ready handshake.
- Returns read data to the winning requester and pulses its ack.
- Sits between the control unit / datapath and the memory block.

Parameters:
- AW, 8, address width (memory depth 2^AW words)
- DW, 16, data word width
- TIMEOUT, 15, max cycles spent in WAIT before abort; timer width 4 bits at default

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  AW  fetch word address
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  DW  registered fetch data
- d_req  in  1  data request; level, held until d_ack
- d_rwn  in  1  1 = read, 0 = write
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse
- d_rdata  out  DW  registered load data; updated on reads only
- mem_start  out  1  memory start strobe
- mem_rwn  out  1  memory read/not-write
- mem_address  out  AW  memory address
- mem_data_in  out  DW  memory write data
- mem_data_out  in  DW  memory read data
- mem_ready  in  1  memory idle (1) / busy (0)
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - mem_start=0, mem_rwn=1, mem_address=0, mem_data_in=0
  - if_ack=d_ack=0, if_rdata=d_rdata=0
  - busy=0, timeout_err=0
  - last_grant=FETCH, state=IDLE
- Reset asserted mid-transaction: immediate return to IDLE with the reset values above; no ack is issued for the aborted transaction.
- Requester contract: address, data and rwn must stay stable from req high until the ack cycle. A req still high in the cycle after its ack is treated as a new request.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Only d_req: grant DATA.
  - Only if_req: grant FETCH.
  - Both: grant the requester that is not last_grant. After reset this means DATA wins the first tie.
  - On grant: latch mem_address, mem_rwn (forced to 1 for FETCH), mem_data_in (d_wdata, or 0 for FETCH) and the grant id; update last_grant; go to ISSUE.
  - A grant is made in IDLE only if mem_ready=1; otherwise stay in IDLE.
- ISSUE:
  - mem_start=1 for exactly this one cycle; clear seen_low and the timer.
  - Go to WAIT.
- WAIT:
  - mem_start=0; timer increments every cycle.
  - mem_ready=0 sets seen_low.
  - When seen_low=1 and mem_ready=1: if a read, capture mem_data_out into if_rdata or d_rdata per grant id; go to ACK.
  - If the timer reaches TIMEOUT first: set timeout_err, leave the rdata registers unchanged, go to ACK.
- ACK:
  - Pulse if_ack or d_ack for one cycle, per grant id.
  - Go to IDLE; no arbitration takes place in this cycle.
- Latency, measured from the first IDLE cycle with req high to the ack cycle: 4 + mem_address[1:0] cycles, given the memory's ready drop one cycle after start and its addr[1:0] countdown.
- Throughput: at most one transaction per 4 + addr[1:0] cycles, plus one IDLE cycle between transactions.
- Simultaneous req deassertion and grant is not legal.
- if_ack and d_ack are never high together.
- mem_start is never high outside ISSUE.

Test Plan:
- Reset; mem[0]=0x6884; if_req, if_addr=0x00 → if_ack at cycle 4, if_rdata=0x6884; mem_start high for exactly 1 cycle.
- d_req read, d_addr=0xF5 (mem[0xF5]=0x0008, addr[1:0]=01) → d_ack at cycle 5, d_rdata=0x0008; if_rdata unchanged.
- d_req write d_addr=0x00, d_wdata=0x1234 → d_ack, d_rdata unchanged; then fetch 0x00 → if_rdata=0x1234.
- After reset, assert both reqs and hold each until acked, twice → grant order DATA, FETCH, DATA, FETCH; acks never overlap.
- Stub memory holding mem_ready=0 after start → timeout_err=1 after 15 WAIT cycles, then an ack pulse with rdata unchanged; timeout_err stays 1 until reset.
- Assert reset during WAIT → next cycle state=IDLE, busy=0, no ack; a subsequent fetch of 0x00 completes normally.
